// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : 32-bit registered ALU with zero/carry/overflow flags.
//               Optional multiply on code 1011 when ALU_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ALU_control,
    output logic [31:0] ALU_result,
    output logic        zero_flag,
    output logic        carry_flag,
    output logic        overflow_flag
);

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_XOR  = 4'b0010;
    localparam logic [3:0] c_OP_ADD  = 4'b0011;
    localparam logic [3:0] c_OP_SUB  = 4'b0100;
    localparam logic [3:0] c_OP_SLL  = 4'b0101;
    localparam logic [3:0] c_OP_SRL  = 4'b0110;
    localparam logic [3:0] c_OP_SRA  = 4'b0111;
    localparam logic [3:0] c_OP_SLT  = 4'b1000;
    localparam logic [3:0] c_OP_SLTU = 4'b1001;
    localparam logic [3:0] c_OP_NOR  = 4'b1010;
`ifdef ALU_MUL_EN
    localparam logic [3:0] c_OP_MUL  = 4'b1011;
`endif

    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [4:0]  w_shamt;
    logic        w_slt;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic [31:0] w_result;
    logic        w_carry;
    logic        w_ovf;
`ifdef ALU_MUL_EN
    logic [31:0] w_prod;
    assign w_prod = a * b;
`endif

    assign w_sum     = {1'b0, a} + {1'b0, b};
    // Bit 32 of the 33-bit difference is the borrow; no-borrow is its inverse.
    assign w_diff    = {1'b0, a} - {1'b0, b};
    assign w_shamt   = b[4:0];
    assign w_slt     = $signed(a) < $signed(b);
    assign w_add_ovf = (a[31] == b[31]) && (w_sum[31] != a[31]);
    assign w_sub_ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);

    always_comb begin
        w_result = 32'd0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (ALU_control)
            c_OP_AND:  w_result = a & b;
            c_OP_OR:   w_result = a | b;
            c_OP_XOR:  w_result = a ^ b;
            c_OP_ADD: begin
                w_result = w_sum[31:0];
                w_carry  = w_sum[32];
                w_ovf    = w_add_ovf;
            end
            c_OP_SUB: begin
                w_result = w_diff[31:0];
                w_carry  = ~w_diff[32];
                w_ovf    = w_sub_ovf;
            end
            c_OP_SLL:  w_result = a << w_shamt;
            c_OP_SRL:  w_result = a >> w_shamt;
            c_OP_SRA:  w_result = $signed(a) >>> w_shamt;
            c_OP_SLT:  w_result = {31'd0, w_slt};
            c_OP_SLTU: w_result = {31'd0, w_diff[32]};
            c_OP_NOR:  w_result = ~(a | b);
`ifdef ALU_MUL_EN
            c_OP_MUL:  w_result = w_prod;
`endif
            default:   w_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALU_result    <= 32'd0;
            zero_flag     <= 1'b1;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            ALU_result    <= w_result;
            zero_flag     <= (w_result == 32'd0);
            carry_flag    <= w_carry;
            overflow_flag <= w_ovf;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module      : tb_alu
// Description : Scoreboard bench for alu; honours ALU_MUL_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALU_control;
    logic [31:0] ALU_result;
    logic        zero_flag;
    logic        carry_flag;
    logic        overflow_flag;

    int   total;
    int   bad;
    exp_t sb[$];

    alu dut (
        .clk           (clk),
        .reset         (reset),
        .a             (a),
        .b             (b),
        .ALU_control   (ALU_control),
        .ALU_result    (ALU_result),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [3:0] op);
        exp_t        e;
        logic [63:0] wide;
        longint      sx;
        longint      sy;
        longint      s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e  = '0;
        case (op)
            4'd0:  e.r = x & y;
            4'd1:  e.r = x | y;
            4'd2:  e.r = x ^ y;
            4'd3: begin
                wide = {32'd0, x} + {32'd0, y};
                e.r  = wide[31:0];
                e.c  = wide[32];
                s    = sx + sy;
                e.v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: begin
                e.r = x - y;
                e.c = (x >= y);
                s   = sx - sy;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd5:  e.r = x << y[4:0];
            4'd6:  e.r = x >> y[4:0];
            4'd7:  e.r = 32'($signed(x) >>> y[4:0]);
            4'd8:  e.r = (sx < sy) ? 32'd1 : 32'd0;
            4'd9:  e.r = (x < y) ? 32'd1 : 32'd0;
            4'd10: e.r = ~(x | y);
`ifdef ALU_MUL_EN
            4'd11: begin
                wide = {32'd0, x} * {32'd0, y};
                e.r  = wide[31:0];
            end
`endif
            default: e.r = 32'd0;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    // Drives one operation half a cycle before the capturing edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        @(negedge clk);
        a           = x;
        b           = y;
        ALU_control = op;
        sb.push_back(model(x, y, op));
    endtask

    task automatic test_reset;
        exp_t got;
        exp_t exp;
        #1;
        got = {ALU_result, zero_flag, carry_flag, overflow_flag};
        exp = {32'd0, 1'b1, 1'b0, 1'b0};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_state: got %h required %h", got, exp);
        end
        repeat (2) @(posedge clk);
        #1;
        got = {ALU_result, zero_flag, carry_flag, overflow_flag};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_hold: got %h required %h", got, exp);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] op);
        exp_t got;
        exp_t exp;
        issue(x, y, op);
        @(posedge clk);
        #1;
        got = {ALU_result, zero_flag, carry_flag, overflow_flag};
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: a=%h b=%h op=%h got %h required %h", name, x, y, op, got, exp);
        end
    endtask

    task automatic test_logic;
        run_vec("and",   32'hF0F0_1234, 32'h0FF0_FFFF, 4'd0);
        run_vec("or",    32'hF000_0000, 32'h0000_000F, 4'd1);
        run_vec("xor",   32'hAAAA_5555, 32'hFFFF_0000, 4'd2);
        run_vec("nor",   32'h0000_0000, 32'h0000_0000, 4'd10);
        run_vec("nor2",  32'hFFFF_0000, 32'h0000_FFFF, 4'd10);
        run_vec("unused12", 32'h1234_5678, 32'h1, 4'd12);
        run_vec("unused15", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15);
    endtask

    task automatic test_arith;
        run_vec("add_1_2",     32'h1, 32'h2, 4'd3);
        run_vec("add_a_b",     32'hA, 32'hB, 4'd3);
        run_vec("add_wrap",    32'hFFFF_FFFF, 32'h1, 4'd3);
        run_vec("add_ovf",     32'h7FFF_FFFF, 32'h1, 4'd3);
        run_vec("add_neg_ovf", 32'h8000_0000, 32'h8000_0000, 4'd3);
        run_vec("sub_ovf",     32'h8000_0000, 32'h1, 4'd4);
        run_vec("sub_eq",      32'h1234, 32'h1234, 4'd4);
        run_vec("sub_borrow",  32'h1, 32'h2, 4'd4);
        run_vec("sub_ovf2",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd4);
    endtask

    task automatic test_shift_cmp;
        run_vec("sra",      32'h8000_0000, 32'h24, 4'd7);
        run_vec("sll",      32'h0000_0001, 32'hFFFF_FFFF, 4'd5);
        run_vec("srl",      32'h8000_0000, 32'h0000_0004, 4'd6);
        run_vec("sra_pos",  32'h4000_0000, 32'h1E, 4'd7);
        run_vec("slt",      32'hFFFF_FFFF, 32'h1, 4'd8);
        run_vec("sltu",     32'hFFFF_FFFF, 32'h1, 4'd9);
        run_vec("slt_eq",   32'h5, 32'h5, 4'd8);
        run_vec("sltu_lt",  32'h1, 32'hFFFF_FFFF, 4'd9);
    endtask

    task automatic test_mul;
        run_vec("mul_big", 32'h0001_0000, 32'h0001_0000, 4'd11);
        run_vec("mul_7x6", 32'h7, 32'h6, 4'd11);
        run_vec("mul_hi",  32'hFFFF_FFFF, 32'h3, 4'd11);
    endtask

    task automatic test_async_reset;
        exp_t got;
        exp_t exp;
        run_vec("pre_reset_add", 32'h1, 32'h2, 4'd3);
        issue(32'h5, 32'h5, 4'd3);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        got = {ALU_result, zero_flag, carry_flag, overflow_flag};
        exp = {32'd0, 1'b1, 1'b0, 1'b0};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL async_reset: got %h required %h", got, exp);
        end
        @(posedge clk);
        #1;
        got = {ALU_result, zero_flag, carry_flag, overflow_flag};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_discard: got %h required %h", got, exp);
        end
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(model(a, b, ALU_control));
        @(posedge clk);
        #1;
        got = {ALU_result, zero_flag, carry_flag, overflow_flag};
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_release: got %h required %h", got, exp);
        end
    endtask

    task automatic test_back_to_back;
        exp_t        got;
        exp_t        exp;
        exp_t        last;
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  op;
        last = {ALU_result, zero_flag, carry_flag, overflow_flag};
        for (int i = 0; i < 300; i++) begin
            x  = $urandom;
            y  = $urandom;
            op = 4'($urandom_range(15, 0));
            if (i % 7 == 0) y = x;
            if (i % 11 == 0) x = 32'h8000_0000;
            issue(x, y, op);
            #3;
            got = {ALU_result, zero_flag, carry_flag, overflow_flag};
            total++;
            if (got !== last) begin
                bad++;
                $display("FAIL hold_between_edges: got %h required %h", got, last);
            end
            @(posedge clk);
            #1;
            got = {ALU_result, zero_flag, carry_flag, overflow_flag};
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b2b_scoreboard_empty: got %h required entry", got);
            end else begin
                exp = sb.pop_front();
                last = exp;
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL b2b: a=%h b=%h op=%h got %h required %h", x, y, op, got, exp);
                end
            end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        a           = 32'd0;
        b           = 32'd0;
        ALU_control = 4'd0;
        test_reset();
        test_logic();
        test_arith();
        test_shift_cmp();
        test_mul();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
